fp_adder: RTL and testbench
===========================

Name: fp_adder

Overview:
- Parameterised floating-point adder with an IEEE-754-style sign/exponent/fraction layout.
- A two-phase (toggle) request starts one addition of two operands. The result is presented on tx_data and announced by a one-cycle ack pulse.
- Sits as a handshaked arithmetic slave beside a controller that toggles req and waits for ack.

Parameters:
MSB  31  index of the sign bit; word width is MSB+1
FMSB  22  index of the top fraction bit; fraction width FW=FMSB+1, exponent width EW=MSB-FMSB-1 (8 by default), bias=2^(EW-1)-1

Ports:
clk  in  1  clock; all state changes on the rising edge
rstn  in  1  reset, asynchronous, active-high
enable  in  1  block enable; low forces idle
req  in  1  toggle request; any change of level while idle and enabled starts one operation
ack  out  1  one-cycle high pulse when tx_data holds the new result
rx_data_1  in  MSB+1  operand A {sign, exponent, fraction}
rx_data_2  in  MSB+1  operand B, same format
tx_data  out  MSB+1  result A+B, held until the next completion

Behaviour:
- Reset (rstn=1, asynchronous): tx_data=0, ack=0, state IDLE, req_q=0.
- Request detect: req_q samples req every cycle. Start when state=IDLE, enable=1 and req!=req_q. rx_data_1/2 are captured on that same edge.
- enable=0: state forced to IDLE, ack=0, req_q still tracks req, so toggles made while disabled are lost. tx_data is unchanged.
- Dropping enable mid-operation aborts it: no ack, tx_data unchanged.
- Toggles of req while busy are ignored. req_q updates, so no queued second operation occurs.
- FSM: IDLE -> UNPACK -> ALIGN -> ADD -> NORM -> ROUND -> IDLE.
  - ack=1 and tx_data updated on the ROUND->IDLE edge.
  - ack falls the following cycle.
  - Latency: ack is high in the 5th cycle after the capture edge.
  - A new request is accepted in the cycle after ack.
- UNPACK:
  - exp=0 is treated as zero; subnormals are flushed to zero.
  - Otherwise the hidden 1 is prepended to the fraction.
  - exp=all-ones with fraction≠0 is NaN; with fraction=0 it is Inf.
- ALIGN:
  - Swap operands so A has the larger magnitude (exponent, then fraction).
  - Right-shift B's mantissa by the exponent difference, keeping guard, round and sticky bits.
  - Differences ≥ FW+3 leave only sticky.
- ADD: same signs add mantissas; otherwise subtract B from A. Result sign = sign of A.
- NORM:
  - Carry-out: shift right 1, exponent+1, sticky ORs in the lost bit.
  - Otherwise left-shift by the leading-zero count (combinational), exponent decremented accordingly.
  - Exponent ≤0 after shift: flush to signed zero.
- ROUND:
  - Round to nearest, ties to even.
  - Rounding carry renormalises and increments the exponent.
  - Exponent reaching all-ones gives ±Inf (fraction 0).
- Specials, with priority over arithmetic:
  - Any NaN -> quiet NaN {0, all-ones exp, MSB of fraction set, rest 0}.
  - Inf + (-Inf) -> the same quiet NaN.
  - Inf + finite -> that Inf.
  - Zero + X -> X.
  - Exact cancellation -> +0.
  - (-0)+(-0) -> -0.
- Implementation: all datapath registers are internal; no combinational path from inputs to outputs.

Test Plan:
1. Reset pulse, enable=1, A=0x3F800000, B=0x3F800000, toggle req 0->1 -> exactly one ack pulse 5 cycles after capture; tx_data=0x40000000.
2. A=0x3FC00000 (1.5), B=0xBF000000 (-0.5), toggle req -> tx_data=0x3F800000. Then A=0x3F800000, B=0xBF800000 -> tx_data=0x00000000.
3. Rounding: A=0x3F800000, B=0x33800000 (tie) -> 0x3F800000. A=0x3F800001, B=0x33800000 -> 0x3F800002 (ties-to-even).
4. Overflow/specials:
   - 0x7F7FFFFF+0x7F7FFFFF -> 0x7F800000.
   - 0x7F800000+0xFF800000 -> 0x7FC00000.
   - 0x7FC00000+0x3F800000 -> 0x7FC00000.
5. Handshake:
   - enable=0 then toggle req -> no ack, tx_data unchanged. Raise enable -> still no ack until the next toggle.
   - Drop enable 2 cycles into an operation -> no ack.
   - Assert rstn mid-operation -> tx_data=0, ack=0 immediately.
6. Random: 300 operations, sign random, exponents within bias±32, random fractions, req toggled each time after ack -> tx_data matches a reference model (FTZ, RNE); one ack per toggle.

Source files
------------

// File: rtl/fp_adder_if.sv
`default_nettype none
// ============================================================================
// Module   : fp_adder_if
// Purpose  : Toggle-request operand/result bundle for fp_adder
// Revision : 1.0
// ============================================================================
interface fp_adder_if #(
    parameter int MSB = 31
);
    logic           enable;
    logic           req;
    logic           ack;
    logic [MSB:0]   rx_data_1;
    logic [MSB:0]   rx_data_2;
    logic [MSB:0]   tx_data;

    modport slave (
        input  enable, req, rx_data_1, rx_data_2,
        output ack, tx_data
    );

    modport master (
        output enable, req, rx_data_1, rx_data_2,
        input  ack, tx_data
    );
endinterface
`default_nettype wire

// File: rtl/fp_adder.sv
`default_nettype none
// ============================================================================
// Module   : fp_adder
// Purpose  : Multi-cycle floating-point adder, flush-to-zero, round-nearest-even
// Revision : 1.0
// ============================================================================
module fp_adder #(
    parameter int MSB  = 31,
    parameter int FMSB = 22
) (
    input  wire         clk,
    input  wire         rstn,
    fp_adder_if.slave   bus
);
    localparam int FW  = FMSB + 1;
    localparam int EW  = MSB - FMSB - 1;
    localparam int XW  = FW + 4;              // hidden + fraction + guard/round/sticky
    localparam int ZW  = EW + 2;              // exponent with sign and carry headroom
    localparam int LZW = $clog2(XW + 1);
    localparam logic [EW-1:0] EMAX = '1;
    localparam logic [MSB:0]  QNAN = {1'b0, EMAX, 1'b1, {(FW-1){1'b0}}};

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_UNPACK = 3'd1;
    localparam logic [2:0] S_ALIGN  = 3'd2;
    localparam logic [2:0] S_ADD    = 3'd3;
    localparam logic [2:0] S_NORM   = 3'd4;
    localparam logic [2:0] S_ROUND  = 3'd5;

    logic [2:0]     state_q, state_d;
    logic           req_q, ack_q;
    logic [MSB:0]   tx_data_q;
    logic [MSB:0]   a_q, b_q, spec_val_q;
    logic [MSB+1:0] ua_q, ub_q;
    logic           spec_q, sign_q, sub_q, cancel_q, ftz_q;
    logic [ZW-1:0]  exp_q;
    logic [XW-1:0]  ma_q, mb_q, norm_q;
    logic [XW:0]    sum_q;

    logic           w_start;
    logic           w_za, w_zb, w_nan_a, w_nan_b, w_inf_a, w_inf_b;
    logic           w_spec;
    logic [MSB:0]   w_spec_val;
    logic           w_swap;
    logic [MSB+1:0] w_big, w_small;
    logic [EW-1:0]  w_diff;
    logic [2*XW-1:0] w_wide;
    logic [XW-1:0]  w_mb_al;
    logic [LZW-1:0] w_lz;
    logic           w_found;
    logic [XW-1:0]  w_norm;
    logic [ZW-1:0]  w_nexp, w_rexp;
    logic           w_rup;
    logic [FW+1:0]  w_rmant;
    logic [FMSB:0]  w_rfrac;
    logic [MSB:0]   w_result;

    assign w_start = (state_q == S_IDLE) && bus.enable && (bus.req != req_q);

    // Operand classification (subnormals count as zero)
    assign w_za    = (a_q[MSB-1:FW] == '0);
    assign w_zb    = (b_q[MSB-1:FW] == '0);
    assign w_nan_a = (a_q[MSB-1:FW] == EMAX) && (a_q[FMSB:0] != '0);
    assign w_nan_b = (b_q[MSB-1:FW] == EMAX) && (b_q[FMSB:0] != '0);
    assign w_inf_a = (a_q[MSB-1:FW] == EMAX) && (a_q[FMSB:0] == '0);
    assign w_inf_b = (b_q[MSB-1:FW] == EMAX) && (b_q[FMSB:0] == '0);

    always_comb begin
        w_spec     = 1'b1;
        w_spec_val = QNAN;
        if (w_nan_a || w_nan_b)                                 w_spec_val = QNAN;
        else if (w_inf_a && w_inf_b && (a_q[MSB] != b_q[MSB]))  w_spec_val = QNAN;
        else if (w_inf_a)                                       w_spec_val = a_q;
        else if (w_inf_b)                                       w_spec_val = b_q;
        else if (w_za && w_zb) w_spec_val = {a_q[MSB] & b_q[MSB], {MSB{1'b0}}};
        else if (w_za)                                          w_spec_val = b_q;
        else if (w_zb)                                          w_spec_val = a_q;
        else                                                    w_spec     = 1'b0;
    end

    // Alignment: larger magnitude goes to A, B is shifted with sticky collapse
    assign w_swap  = ub_q[MSB:0] > ua_q[MSB:0];
    assign w_big   = w_swap ? ub_q : ua_q;
    assign w_small = w_swap ? ua_q : ub_q;
    assign w_diff  = w_big[MSB:FW+1] - w_small[MSB:FW+1];
    assign w_wide  = {w_small[FW:0], 3'b000, {XW{1'b0}}} >> w_diff;
    assign w_mb_al = (32'(w_diff) >= XW) ? {{(XW-1){1'b0}}, 1'b1}
                                         : {w_wide[2*XW-1:XW+1], |w_wide[XW:0]};

    always_comb begin
        w_lz    = '0;
        w_found = 1'b0;
        for (int i = XW - 1; i >= 0; i--) begin
            if (!w_found) begin
                if (sum_q[i]) w_found = 1'b1;
                else          w_lz    = w_lz + LZW'(1);
            end
        end
        if (sum_q[XW]) begin
            w_norm = {sum_q[XW:2], sum_q[1] | sum_q[0]};
            w_nexp = exp_q + ZW'(1);
        end else begin
            w_norm = sum_q[XW-1:0] << w_lz;
            w_nexp = exp_q - ZW'(w_lz);
        end
    end

    always_comb begin
        w_rup   = norm_q[2] & (norm_q[3] | norm_q[1] | norm_q[0]);
        w_rmant = {1'b0, norm_q[XW-1:3]} + {{(FW+1){1'b0}}, w_rup};
        w_rexp  = w_rmant[FW+1] ? exp_q + ZW'(1) : exp_q;
        w_rfrac = w_rmant[FW+1] ? w_rmant[FW:1] : w_rmant[FMSB:0];
        if (spec_q)                        w_result = spec_val_q;
        else if (cancel_q)                 w_result = '0;
        else if (ftz_q)                    w_result = {sign_q, {MSB{1'b0}}};
        else if (w_rexp >= {2'b00, EMAX})  w_result = {sign_q, EMAX, {FW{1'b0}}};
        else                               w_result = {sign_q, w_rexp[EW-1:0], w_rfrac};
    end

    always_comb begin
        state_d = state_q;
        if (!bus.enable) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:   if (w_start) state_d = S_UNPACK;
                S_UNPACK: state_d = S_ALIGN;
                S_ALIGN:  state_d = S_ADD;
                S_ADD:    state_d = S_NORM;
                S_NORM:   state_d = S_ROUND;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_q   <= S_IDLE;
            req_q     <= 1'b0;
            ack_q     <= 1'b0;
            tx_data_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= bus.req;
            ack_q   <= bus.enable && (state_q == S_ROUND);
            if (bus.enable && (state_q == S_ROUND)) tx_data_q <= w_result;
        end
    end

    always_ff @(posedge clk) begin
        case (state_q)
            S_IDLE: begin
                if (w_start) begin
                    a_q <= bus.rx_data_1;
                    b_q <= bus.rx_data_2;
                end
            end
            S_UNPACK: begin
                ua_q       <= {a_q[MSB:FW], 1'b1, a_q[FMSB:0]};
                ub_q       <= {b_q[MSB:FW], 1'b1, b_q[FMSB:0]};
                spec_q     <= w_spec;
                spec_val_q <= w_spec_val;
            end
            S_ALIGN: begin
                sign_q <= w_big[MSB+1];
                sub_q  <= w_big[MSB+1] ^ w_small[MSB+1];
                exp_q  <= ZW'(w_big[MSB:FW+1]);
                ma_q   <= {w_big[FW:0], 3'b000};
                mb_q   <= w_mb_al;
            end
            S_ADD: begin
                sum_q <= sub_q ? ({1'b0, ma_q} - {1'b0, mb_q}) : ({1'b0, ma_q} + {1'b0, mb_q});
            end
            S_NORM: begin
                norm_q   <= w_norm;
                exp_q    <= w_nexp;
                cancel_q <= (sum_q == '0);
                ftz_q    <= w_nexp[ZW-1] || (w_nexp == '0);
            end
            default: ;
        endcase
    end

    assign bus.ack     = ack_q;
    assign bus.tx_data = tx_data_q;
endmodule
`default_nettype wire

// File: tb/tb_fp_adder.sv
`default_nettype none
// tb_fp_adder: directed and random additions checked every cycle against an
// exact-integer reference (flush-to-zero, round-nearest-even).
module tb_fp_adder;
    logic clk = 1'b0;
    logic rstn;

    fp_adder_if #(.MSB(31)) bus ();
    fp_adder #(.MSB(31), .FMSB(22)) dut (.clk(clk), .rstn(rstn), .bus(bus));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_checks    = 0;
    int          n_fail      = 0;
    logic [31:0] model_tx    = '0;
    logic [31:0] exp_val     = '0;
    int          exp_ack_cyc = -1;
    bit          chk_on      = 1'b0;
    logic [31:0] last_lit    = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        n_checks++;
        if (act !== req_v) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req_v, cyc);
        end
    endtask

    // Exact sum of two singles on wide integers, then one rounding step.
    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
        logic [319:0] xa, xb, s, q, rem, half;
        int ea, eb, emin, p, e, sh;
        logic sa, sb, sr;
        sa = a[31];
        sb = b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0)) return 32'h7FC00000;
        if (ea == 255 && eb == 255) return (sa != sb) ? 32'h7FC00000 : a;
        if (ea == 255) return a;
        if (eb == 255) return b;
        if (ea == 0 && eb == 0) return {sa & sb, 31'd0};
        if (ea == 0) return b;
        if (eb == 0) return a;
        emin = (ea < eb) ? ea : eb;
        xa = 320'({1'b1, a[22:0]}) << (ea - emin);
        xb = 320'({1'b1, b[22:0]}) << (eb - emin);
        if (sa == sb)      begin s = xa + xb; sr = sa; end
        else if (xa >= xb) begin s = xa - xb; sr = sa; end
        else               begin s = xb - xa; sr = sb; end
        if (s == 0) return 32'h00000000;
        p = 0;
        for (int i = 0; i < 320; i++) if (s[i]) p = i;
        e = emin + p - 23;
        if (e <= 0) return {sr, 31'd0};
        if (p > 23) begin
            sh   = p - 23;
            q    = s >> sh;
            rem  = s & ((320'(1) << sh) - 320'(1));
            half = 320'(1) << (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + 320'(1);
            if (q[24]) begin q = q >> 1; e++; end
        end else begin
            q = s << (23 - p);
        end
        if (e >= 255) return {sr, 8'hFF, 23'd0};
        return {sr, 8'(e), q[22:0]};
    endfunction

    function automatic logic [31:0] rnd_fp();
        logic [7:0] e;
        e = 8'($urandom_range(159, 95));
        return {1'($urandom), e, 23'($urandom)};
    endfunction

    // Every-cycle comparison of ack timing and the held result
    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) begin
                if (cyc == exp_ack_cyc) model_tx = exp_val;
                check("ack", 32'(bus.ack), 32'(cyc == exp_ack_cyc));
                check("tx_data", bus.tx_data, model_tx);
            end
        end
    end

    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.rx_data_1 = a;
        bus.rx_data_2 = b;
        bus.req       = ~bus.req;
        exp_val       = ref_add(a, b);
        exp_ack_cyc   = cyc + 6;
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] lit, input bit use_lit);
        int w;
        launch(a, b);
        w = 0;
        while (bus.ack !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("ack_seen", 32'(bus.ack), 32'd1);
        if (use_lit) check("directed_result", bus.tx_data, lit);
        @(negedge clk);
    endtask

    logic [31:0] dir_a [11] = '{32'h3F800000, 32'h3FC00000, 32'h3F800000, 32'h3F800000,
                                32'h3F800001, 32'h7F7FFFFF, 32'h7F800000, 32'h7FC00000,
                                32'h80000000, 32'h00000000, 32'h7F800000};
    logic [31:0] dir_b [11] = '{32'h3F800000, 32'hBF000000, 32'hBF800000, 32'h33800000,
                                32'h33800000, 32'h7F7FFFFF, 32'hFF800000, 32'h3F800000,
                                32'h80000000, 32'hC0400000, 32'h3F800000};
    logic [31:0] dir_r [11] = '{32'h40000000, 32'h3F800000, 32'h00000000, 32'h3F800000,
                                32'h3F800002, 32'h7F800000, 32'h7FC00000, 32'h7FC00000,
                                32'h80000000, 32'hC0400000, 32'h7F800000};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not complete, failures so far %0d", n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn          = 1'b1;
        bus.enable    = 1'b0;
        bus.req       = 1'b0;
        bus.rx_data_1 = '0;
        bus.rx_data_2 = '0;
        repeat (3) @(negedge clk);
        check("reset_tx", bus.tx_data, 32'h0);
        check("reset_ack", 32'(bus.ack), 32'h0);
        rstn       = 1'b0;
        bus.enable = 1'b1;
        chk_on     = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            do_op(dir_a[i], dir_b[i], dir_r[i], 1'b1);
            last_lit = dir_r[i];
        end

        // Toggle while disabled is lost, even after enable returns
        @(negedge clk);
        bus.enable = 1'b0;
        bus.req    = ~bus.req;
        repeat (8) @(negedge clk);
        check("disabled_hold", bus.tx_data, last_lit);
        bus.enable = 1'b1;
        repeat (8) @(negedge clk);
        check("reenable_hold", bus.tx_data, last_lit);

        // Abort by dropping enable two cycles into an operation
        launch(32'h40000000, 32'h40000000);
        repeat (2) @(negedge clk);
        bus.enable  = 1'b0;
        exp_ack_cyc = -1;
        repeat (8) @(negedge clk);
        check("abort_hold", bus.tx_data, last_lit);
        bus.enable = 1'b1;
        repeat (2) @(negedge clk);

        // Asynchronous reset in the middle of an operation
        launch(32'h40400000, 32'h3F800000);
        repeat (3) @(negedge clk);
        #2;
        rstn        = 1'b1;
        bus.req     = 1'b0;
        model_tx    = '0;
        exp_ack_cyc = -1;
        #1;
        check("rst_async_tx", bus.tx_data, 32'h0);
        check("rst_async_ack", 32'(bus.ack), 32'h0);
        @(negedge clk);
        rstn = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 300; i++) begin
            do_op(rnd_fp(), rnd_fp(), 32'h0, 1'b0);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
